rvfi_retire_serializer: RTL and testbench

- Sits between a multi-retire core's RVFI port and the per-instruction formal checkers.
- Captures up to NRET retirements per cycle and replays them one per cycle, in channel order, on a single RVFI channel.
- Downstream checkers then run with NRET=1.
- Flags buffer overflow and non-consecutive rvfi_order as sticky error outputs that the harness asserts low.

---
 rtl/rvfi_retire_serializer.sv | 129 ++++++++++++
 tb/tb_rvfi_retire_serializer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvfi_retire_serializer.sv
// rtl/rvfi_retire_serializer.sv - serializes up to NRET RVFI retirements per cycle onto one channel
// Strict FIFO replay (cycle order, then channel order) with sticky overflow and order-gap flags.
module rvfi_retire_serializer #(
  parameter int NRET  = 2,
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 8,
  parameter int REC_W = ILEN + 3 + 5 + 5 + XLEN + XLEN + 5 + XLEN + XLEN + XLEN + XLEN
                        + XLEN / 8 + XLEN / 8 + XLEN + XLEN
) (
  input  logic                        clock,
  input  logic                        resetn,
  input  logic                        enable,
  input  logic [NRET-1:0]             rvfi_valid,
  input  logic [NRET*64-1:0]          rvfi_order,
  input  logic [NRET*REC_W-1:0]       rvfi_rec,
  output logic                        out_valid,
  output logic [63:0]                 out_order,
  output logic [REC_W-1:0]            out_rec,
  output logic                        overflow,
  output logic                        order_error,
  output logic [$clog2(DEPTH):0]      level
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam int EW = 64 + REC_W;

  logic [EW-1:0]    mem_q [DEPTH];
  logic [EW-1:0]    mem_d [DEPTH];
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             out_valid_q, out_valid_d;
  logic [63:0]      out_order_q, out_order_d;
  logic [REC_W-1:0] out_rec_q, out_rec_d;
  logic             overflow_q, overflow_d;
  logic             order_error_q, order_error_d;
  logic             seen_q, seen_d;

  logic             pop;
  logic             taken;
  logic [LW-1:0]    base;
  logic [LW-1:0]    n;

  always_comb begin
    mem_d         = mem_q;
    rptr_d        = rptr_q;
    out_valid_d   = 1'b0;
    out_order_d   = out_order_q;
    out_rec_d     = out_rec_q;
    overflow_d    = overflow_q;
    order_error_d = order_error_q;
    seen_d        = seen_q;
    pop           = (level_q != '0);
    taken         = pop;
    base          = level_q - LW'(pop);
    n             = '0;

    if (pop) begin
      out_valid_d              = 1'b1;
      {out_order_d, out_rec_d} = mem_q[rptr_q];
      rptr_d                   = rptr_q + 1'b1;
    end

    // With an empty buffer the lowest captured channel bypasses straight to the output.
    for (int i = 0; i < NRET; i++) begin
      if (enable && rvfi_valid[i]) begin
        if (!taken) begin
          taken       = 1'b1;
          out_valid_d = 1'b1;
          out_order_d = rvfi_order[i*64 +: 64];
          out_rec_d   = rvfi_rec[i*REC_W +: REC_W];
        end else if ((base + n) < LW'(DEPTH)) begin
          mem_d[wptr_q + n[PW-1:0]] = {rvfi_order[i*64 +: 64], rvfi_rec[i*REC_W +: REC_W]};
          n = n + 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end

    wptr_d  = wptr_q + n[PW-1:0];
    level_d = base + n;

    if (out_valid_d) begin
      if (seen_q && (out_order_d != out_order_q + 64'd1)) begin
        order_error_d = 1'b1;
      end
      seen_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wptr_q        <= '0;
      rptr_q        <= '0;
      level_q       <= '0;
      out_valid_q   <= 1'b0;
      out_order_q   <= '0;
      out_rec_q     <= '0;
      overflow_q    <= 1'b0;
      order_error_q <= 1'b0;
      seen_q        <= 1'b0;
    end else begin
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      level_q       <= level_d;
      out_valid_q   <= out_valid_d;
      out_order_q   <= out_order_d;
      out_rec_q     <= out_rec_d;
      overflow_q    <= overflow_d;
      order_error_q <= order_error_d;
      seen_q        <= seen_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_order   = out_order_q;
  assign out_rec     = out_rec_q;
  assign overflow    = overflow_q;
  assign order_error = order_error_q;
  assign level       = level_q;

endmodule

// File: tb/tb_rvfi_retire_serializer.sv
// tb/tb_rvfi_retire_serializer.sv - self-checking bench for rvfi_retire_serializer
// Directed vector table, hand sequences, and random traffic against a queue reference model.
module tb_rvfi_retire_serializer;

  localparam int NRET  = 2;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 8;
  localparam int REC_W = ILEN + 3 + 5 + 5 + XLEN + XLEN + 5 + XLEN + XLEN + XLEN + XLEN
                         + XLEN / 8 + XLEN / 8 + XLEN + XLEN;

  logic                   clock;
  logic                   resetn;
  logic                   enable;
  logic [NRET-1:0]        rvfi_valid;
  logic [NRET*64-1:0]     rvfi_order;
  logic [NRET*REC_W-1:0]  rvfi_rec;
  logic                   out_valid;
  logic [63:0]            out_order;
  logic [REC_W-1:0]       out_rec;
  logic                   overflow;
  logic                   order_error;
  logic [$clog2(DEPTH):0] level;

  rvfi_retire_serializer #(
    .NRET(NRET), .XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)
  ) dut (
    .clock(clock), .resetn(resetn), .enable(enable),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order), .rvfi_rec(rvfi_rec),
    .out_valid(out_valid), .out_order(out_order), .out_rec(out_rec),
    .overflow(overflow), .order_error(order_error), .level(level)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    logic [63:0]      ord;
    logic [REC_W-1:0] rec;
  } ent_t;

  // Reference model: a bounded queue plus the last emitted retirement.
  ent_t             q[$];
  logic             m_valid;
  logic [63:0]      m_order;
  logic [REC_W-1:0] m_rec;
  logic             m_ovf;
  logic             m_oerr;
  logic             m_seen;
  int               m_peak;
  int               d_peak;

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  v;
    logic [63:0] o0;
    logic [63:0] o1;
    logic        ev;
    logic [63:0] eo;
    logic [3:0]  elvl;
    logic        eovf;
    logic        eoerr;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_rec(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] rand_rec();
    logic [REC_W-1:0] r;
    for (int j = 0; j < REC_W; j++) r[j] = 1'($urandom_range(0, 1));
    return r;
  endfunction

  task automatic model_reset();
    q.delete();
    m_valid = 1'b0;
    m_order = '0;
    m_rec   = '0;
    m_ovf   = 1'b0;
    m_oerr  = 1'b0;
    m_seen  = 1'b0;
  endtask

  task automatic model_edge();
    ent_t cap[$];
    ent_t e;
    logic emitted;
    for (int i = 0; i < NRET; i++) begin
      if (enable && rvfi_valid[i]) begin
        e.ord = rvfi_order[i*64 +: 64];
        e.rec = rvfi_rec[i*REC_W +: REC_W];
        cap.push_back(e);
      end
    end
    emitted = 1'b0;
    if (q.size() > 0) begin
      e = q.pop_front();
      emitted = 1'b1;
    end else if (cap.size() > 0) begin
      e = cap.pop_front();
      emitted = 1'b1;
    end
    foreach (cap[j]) begin
      if (q.size() < DEPTH) q.push_back(cap[j]);
      else m_ovf = 1'b1;
    end
    if (emitted) begin
      if (m_seen && e.ord != m_order + 64'd1) m_oerr = 1'b1;
      m_seen  = 1'b1;
      m_order = e.ord;
      m_rec   = e.rec;
      m_valid = 1'b1;
    end else begin
      m_valid = 1'b0;
    end
    if (q.size() > m_peak) m_peak = q.size();
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(m_valid));
    chk("out_order", out_order, m_order);
    chk_rec("out_rec", out_rec, m_rec);
    chk("level", 64'(level), 64'(q.size()));
    chk("overflow", 64'(overflow), 64'(m_ovf));
    chk("order_error", 64'(order_error), 64'(m_oerr));
    if (int'(level) > d_peak) d_peak = int'(level);
  endtask

  task automatic do_reset();
    resetn     = 1'b0;
    enable     = 1'b0;
    rvfi_valid = '0;
    rvfi_order = '0;
    rvfi_rec   = '0;
    @(posedge clock);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_order", out_order, 64'd0);
    chk_rec("rst_rec", out_rec, '0);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_flags", {62'd0, overflow, order_error}, 64'd0);
    resetn = 1'b1;
    model_reset();
    m_peak = 0;
    d_peak = 0;
  endtask

  task automatic cycle(input logic e, input logic [1:0] v, input logic [63:0] o0, input logic [63:0] o1);
    enable     = e;
    rvfi_valid = v;
    rvfi_order = {o1, o0};
    rvfi_rec   = {rand_rec(), rand_rec()};
    model_edge();
    @(posedge clock);
    #1;
    check_all();
  endtask

  vec_t vecs[$];

  initial begin
    logic [63:0] nxt;
    logic [63:0] oa;
    logic [63:0] ob;
    logic [1:0]  rv;
    logic        re;

    resetn     = 1'b0;
    enable     = 1'b0;
    rvfi_valid = '0;
    rvfi_order = '0;
    rvfi_rec   = '0;
    model_reset();
    m_peak = 0;
    d_peak = 0;

    // rst, en, v, o0, o1 | valid, order, level, overflow, order_error
    vecs.push_back('{1'b1, 1'b1, 2'b11, 64'd0, 64'd1, 1'b1, 64'd0, 4'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b00, 64'd0, 64'd0, 1'b1, 64'd1, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b00, 64'd0, 64'd0, 1'b0, 64'd1, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b1, 2'b10, 64'd9, 64'd5, 1'b1, 64'd5, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 2'b11, 64'd7, 64'd8, 1'b0, 64'd5, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 64'd6, 64'd0, 1'b1, 64'd6, 4'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 2'b01, 64'd9, 64'd0, 1'b1, 64'd9, 4'd0, 1'b0, 1'b1});

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      cycle(vecs[i].en, vecs[i].v, vecs[i].o0, vecs[i].o1);
      chk("vec_valid", 64'(out_valid), 64'(vecs[i].ev));
      chk("vec_order", out_order, vecs[i].eo);
      chk("vec_level", 64'(level), 64'(vecs[i].elvl));
      chk("vec_flags", {62'd0, overflow, order_error}, {62'd0, vecs[i].eovf, vecs[i].eoerr});
    end

    // Ten retirements in five double bursts, then drain.
    do_reset();
    for (int c = 0; c < 5; c++) cycle(1'b1, 2'b11, 64'(2*c), 64'(2*c+1));
    for (int c = 0; c < 6; c++) cycle(1'b1, 2'b00, 64'd0, 64'd0);
    chk("burst_peak", 64'(d_peak), 64'(m_peak));
    chk("burst_last", out_order, 64'd9);
    chk("burst_ovf", 64'(overflow), 64'd0);

    // Sustained double retirement overruns the buffer.
    do_reset();
    for (int c = 0; c < 12; c++) cycle(1'b1, 2'b11, 64'(2*c), 64'(2*c+1));
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'(DEPTH));
    for (int c = 0; c < 10; c++) cycle(1'b1, 2'b00, 64'd0, 64'd0);
    chk("ovf_oerr", 64'(order_error), 64'd1);

    // Order gap 3,4,6 stays flagged through idle until reset.
    do_reset();
    cycle(1'b1, 2'b01, 64'd3, 64'd0);
    cycle(1'b1, 2'b01, 64'd4, 64'd0);
    chk("gap_clean", 64'(order_error), 64'd0);
    cycle(1'b1, 2'b01, 64'd6, 64'd0);
    chk("gap_set", 64'(order_error), 64'd1);
    for (int c = 0; c < 4; c++) cycle(1'b1, 2'b00, 64'd0, 64'd0);
    chk("gap_sticky", 64'(order_error), 64'd1);

    // Asynchronous reset mid-burst with five entries buffered.
    do_reset();
    for (int c = 0; c < 5; c++) cycle(1'b1, 2'b11, 64'(2*c), 64'(2*c+1));
    chk("pre_async_level", 64'(level), 64'd5);
    #2;
    resetn = 1'b0;
    #1;
    chk("async_valid", 64'(out_valid), 64'd0);
    chk("async_order", out_order, 64'd0);
    chk_rec("async_rec", out_rec, '0);
    chk("async_level", 64'(level), 64'd0);
    @(posedge clock);
    #1;
    resetn = 1'b1;
    model_reset();
    cycle(1'b1, 2'b01, 64'd0, 64'd0);
    chk("post_async_order", out_order, 64'd0);
    chk("post_async_flags", {62'd0, overflow, order_error}, 64'd0);
    chk("post_async_level", 64'(level), 64'd0);

    // Random traffic, mostly consecutive orders with occasional jumps.
    do_reset();
    nxt = 64'd100;
    for (int c = 0; c < 400; c++) begin
      re = ($urandom_range(0, 9) != 0);
      rv = 2'($urandom_range(0, 3));
      if (c % 50 > 35) rv = 2'b00;
      if ($urandom_range(0, 39) == 0) nxt = nxt + 64'($urandom_range(2, 9));
      oa = nxt;
      ob = (re && rv[0]) ? nxt + 64'd1 : nxt;
      if (re) nxt = nxt + 64'(rv[0]) + 64'(rv[1]);
      cycle(re, rv, oa, ob);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
